sid_wave_gen: RTL
=================

// Module: sid_wave_gen
// PURPOSE
// - Consumes the 24-bit phase of one SID voice accumulator and produces the 12-bit voice
//   waveform: triangle, sawtooth, pulse, noise, or an AND-combination of them.
// - Produces the accumulator-side controls: hard-sync rise pulse and accumulator clear.
// - Sits between the per-voice phase accumulator and the envelope/DAC mixer. One instance per voice.
// - Runs on the 1 MHz voice clock. The accumulator advances every cycle.
// PARAMETERS
// - PHASE_W   24        accumulator phase width; waveform taps are taken from the top bits
// - OUT_W     12        waveform output width
// - LFSR_SEED 23'h7FFFF8  noise LFSR value after reset or TEST
// PORTS
// - clk           in   1   voice clock, single clock domain
// - rst           in   1   synchronous, active-high reset
// - phase         in   24  current accumulator value of this voice
// - pw            in   12  pulse-width register
// - control       in   8   [0]gate (unused here) [1]sync [2]ring [3]test [4]tri [5]saw [6]pulse [7]noise
// - sync_in       in   1   sync_out of the modulating voice (registered pulse)
// - ring_msb_in   in   1   phase[23] of the modulating voice
// - wave_out      out  12  registered waveform sample
// - sync_out      out  1   registered 1-cycle pulse on the 0->1 transition of this voice's phase[23]
// - acc_clear     out  1   combinational; accumulator must load 0 on the next edge
// BEHAVIOUR
// - Reset (rst=1 at posedge):
//   - wave_out=0, sync_out=0.
//   - prev_msb=0, prev_b19=0.
//   - lfsr=LFSR_SEED.
// - Latency: wave_out reflects phase/pw/control/ring_msb_in sampled 1 cycle earlier.
// - Saw: saw = phase[23:12].
// - Tri:
//   - msb_eff = phase[23] ^ (control[2] & ring_msb_in).
//   - tri = phase[22:11] ^ {12{msb_eff}}.
// - Pulse: pul = (phase[23:12] >= pw) ? 12'hFFF : 12'h000. TEST (control[3]) forces pul = 12'hFFF.
// - Noise:
//   - noi = {lfsr[22],lfsr[20],lfsr[16],lfsr[13],lfsr[11],lfsr[7],lfsr[4],lfsr[2],4'b0}.
// - Output combination:
//   - The selected waveforms (control[7:4]) are bitwise ANDed.
//   - No waveform selected -> wave_out=0.
// - LFSR (23-bit, shift left):
//   - Steps when prev_b19==0 && phase[19]==1.
//   - On a step: lfsr <= {lfsr[21:0], lfsr[22]^lfsr[17]}.
//   - TEST=1: lfsr <= LFSR_SEED every cycle; TEST overrides any step in the same cycle.
//   - An all-zero state cannot be reached from the seed; no lock-up recovery is required.
// - Edge trackers: prev_msb <= phase[23] and prev_b19 <= phase[19] every cycle, including while TEST=1.
// - sync_out: sync_out <= ~prev_msb & phase[23].
//   - No false edge after reset, because the accumulator also resets to 0.
// - acc_clear = control[3] | (control[1] & sync_in). Combinational, no state.
// - Simultaneous events:
//   - sync_in while TEST=1 -> acc_clear=1 (single clear).
//   - Ring without tri selected has no effect on the output.
// - Reset mid-operation: all state returns to reset values on the same edge; next sample is 0.
// STRUCTURE
// - Shared package sid_pkg:
//   - CTRL_* bit index constants.
//   - LFSR_SEED.
//   - LFSR tap constants (22, 17).
//   - Noise output bit-index array.
//   - typedef logic [11:0] sid_sample_t.
// - Sub-module sid_noise_lfsr: ports clk, rst, step, reload, lfsr[22:0].
// - Everything else lives in this module.
// TESTING
// - Reset, then control=0x20, phase=24'h800000 -> wave_out=12'h800 one cycle later.
// - control=0x10, phase=24'hC00000 -> 12'h7FF.
//   - Same, but phase=24'h400000, ring set (0x14), ring_msb_in=1 -> 12'h7FF.
//   - Same with ring_msb_in=0 -> 12'h800.
// - control=0x40, pw=12'h800:
//   - phase=24'h7FF000 -> 12'h000.
//   - phase=24'h800000 -> 12'hFFF.
//   - control=0x48 with any phase -> 12'hFFF.
// - After reset, control=0x80 -> wave_out=12'hFE0.
//   - Drive phase[19] 0->1 once -> lfsr=23'h7FFFF0, wave_out still 12'hFE0.
//   - Assert TEST -> lfsr back to 23'h7FFFF8.
// - Sync:
//   - phase[23] 0->1 -> sync_out=1 for exactly 1 cycle.
//   - control=0x02 with sync_in=1 -> acc_clear=1 in the same cycle.
//   - sync_in=1 with control[1]=0 -> acc_clear=0.
// - Combined waveform: control=0x30, phase=24'hC00000 -> saw 12'hC00 & tri 12'h7FF -> 12'h400.
// - Mid-run reset: assert rst during noise output -> next wave_out=0 and lfsr=seed.

Source files
------------

// File: rtl/sid_pkg.sv
// Shared constants and types for the SID voice waveform generator.
//   - CTRL_* : bit positions inside the voice control register
//   - LFSR_SEED / LFSR_TAP_* : noise LFSR reload value and feedback taps
//   - NOISE_TAPS : LFSR bits routed to the top 8 noise output bits, MSB first
//   - sid_sample_t : one 12-bit waveform sample
package sid_pkg;

  localparam int LFSR_W = 23;

  localparam int CTRL_GATE  = 0;
  localparam int CTRL_SYNC  = 1;
  localparam int CTRL_RING  = 2;
  localparam int CTRL_TEST  = 3;
  localparam int CTRL_TRI   = 4;
  localparam int CTRL_SAW   = 5;
  localparam int CTRL_PULSE = 6;
  localparam int CTRL_NOISE = 7;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 23'h7FFFF8;
  localparam int LFSR_TAP_A = 22;
  localparam int LFSR_TAP_B = 17;

  localparam int NOISE_BITS = 8;
  localparam int NOISE_TAPS [NOISE_BITS] = '{22, 20, 16, 13, 11, 7, 4, 2};

  typedef logic [11:0] sid_sample_t;

endpackage

// File: rtl/sid_noise_lfsr.sv
// 23-bit shift-left noise LFSR.
//   clk    : voice clock
//   rst    : synchronous active-high reset, loads SEED
//   step   : advance one position this cycle
//   reload : load SEED this cycle (wins over step)
//   lfsr   : current register value
module sid_noise_lfsr
  import sid_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              reload,
  output logic [LFSR_W-1:0] lfsr
);

  always_ff @(posedge clk) begin
    if (rst || reload) begin
      lfsr <= SEED;
    end else if (step) begin
      lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B]};
    end
  end

endmodule

// File: rtl/sid_wave_gen.sv
// SID voice waveform generator: turns one voice's accumulator phase into a
// 12-bit waveform sample and produces the accumulator-side sync/clear controls.
//   clk, rst     : voice clock, synchronous active-high reset
//   phase        : this voice's accumulator value
//   pw           : pulse-width register
//   control      : voice control register (gate, sync, ring, test, tri, saw, pulse, noise)
//   sync_in      : sync_out of the modulating voice
//   ring_msb_in  : phase MSB of the modulating voice
//   wave_out     : registered waveform sample (1 cycle after its inputs)
//   sync_out     : registered 1-cycle pulse on a 0->1 of this voice's phase MSB
//   acc_clear    : combinational, accumulator loads 0 on the next edge
module sid_wave_gen
  import sid_pkg::*;
#(
  parameter int                PHASE_W   = 24,
  parameter int                OUT_W     = 12,
  parameter logic [LFSR_W-1:0] LFSR_SEED = sid_pkg::LFSR_SEED
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] phase,
  input  logic [OUT_W-1:0]   pw,
  input  logic [7:0]         control,
  input  logic               sync_in,
  input  logic               ring_msb_in,
  output logic [OUT_W-1:0]   wave_out,
  output logic               sync_out,
  output logic               acc_clear
);

  // Bit 19 of a 24-bit accumulator clocks the noise LFSR.
  localparam int NOISE_CLK_BIT = PHASE_W - 5;

  logic              prev_msb;
  logic              prev_b19;
  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_step;
  logic              msb_eff;
  logic [OUT_W-1:0]  saw_w;
  logic [OUT_W-1:0]  tri_w;
  logic [OUT_W-1:0]  pul_w;
  logic [OUT_W-1:0]  noi_w;
  logic [OUT_W-1:0]  mix_w;

  // Gate belongs to the envelope; low phase bits are below waveform resolution.
  logic unused_bits;
  assign unused_bits = ^{control[CTRL_GATE], phase[PHASE_W-OUT_W-2:0]};

  assign lfsr_step = ~prev_b19 & phase[NOISE_CLK_BIT];
  assign acc_clear = control[CTRL_TEST] | (control[CTRL_SYNC] & sync_in);

  sid_noise_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .step   (lfsr_step),
    .reload (control[CTRL_TEST]),
    .lfsr   (lfsr)
  );

  always_comb begin
    saw_w   = phase[PHASE_W-1 -: OUT_W];
    // Ring modulation replaces the fold bit with an XOR against the modulator MSB.
    msb_eff = phase[PHASE_W-1] ^ (control[CTRL_RING] & ring_msb_in);
    tri_w   = phase[PHASE_W-2 -: OUT_W] ^ {OUT_W{msb_eff}};
    pul_w   = (control[CTRL_TEST] || (saw_w >= pw)) ? '1 : '0;

    noi_w = '0;
    for (int i = 0; i < NOISE_BITS; i++) begin
      noi_w[OUT_W-1-i] = lfsr[NOISE_TAPS[i]];
    end

    // Multiple selected waveforms combine as a bitwise AND.
    mix_w = '1;
    if (control[CTRL_TRI])   mix_w = mix_w & tri_w;
    if (control[CTRL_SAW])   mix_w = mix_w & saw_w;
    if (control[CTRL_PULSE]) mix_w = mix_w & pul_w;
    if (control[CTRL_NOISE]) mix_w = mix_w & noi_w;
    if (control[CTRL_NOISE:CTRL_TRI] == 4'b0000) mix_w = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wave_out <= '0;
      sync_out <= 1'b0;
      prev_msb <= 1'b0;
      prev_b19 <= 1'b0;
    end else begin
      wave_out <= mix_w;
      sync_out <= ~prev_msb & phase[PHASE_W-1];
      prev_msb <= phase[PHASE_W-1];
      prev_b19 <= phase[NOISE_CLK_BIT];
    end
  end

endmodule
